// File: rtl/cpu_ttl_pkg.sv
// Shared constants for the TTL-equivalent CPU datapath blocks.
// Slice width and a cascade width check used by counter chains.
`ifndef CPU_TTL_PKG_SV
`define CPU_TTL_PKG_SV

package cpu_ttl_pkg;

  localparam int SLICE_W = 4;

  function automatic bit width_ok(input int w);
    return (w > 0) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// Chains are built from whole 4-bit slices only.
`define CPU_TTL_WIDTH_CHECK(w) \
  if (!cpu_ttl_pkg::width_ok(w)) begin : g_width_err \
    $error("WIDTH must be a positive multiple of 4"); \
  end

`endif

// File: rtl/ls74161.sv
// One 74LS161-style 4-bit synchronous binary counter slice.
// Async clear, sync load, count on ENP&ENT, RCO = ENT & (q == 4'hF).
module ls74161
  import cpu_ttl_pkg::*;
#(
  parameter logic [SLICE_W-1:0] RST_Q = '0
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load_n,
  input  logic               enp,
  input  logic               ent,
  input  logic [SLICE_W-1:0] d,
  output logic [SLICE_W-1:0] q,
  output logic               rco
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= RST_Q;
    end else if (!load_n) begin
      q <= d;
    end else if (enp && ent) begin
      q <= q + 1'b1;
    end
  end

  // Lookahead carry: independent of enp.
  assign rco = ent & (&q);

endmodule

// File: rtl/ls74161_pc_chain.sv
// Program counter built from cascaded ls74161 slices.
// Slice k is enabled by the RCO of slice k-1; enp fans out to all.
module ls74161_pc_chain
  import cpu_ttl_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco
);

  localparam int NSLICE = WIDTH / SLICE_W;

  `CPU_TTL_WIDTH_CHECK(WIDTH)

  logic [NSLICE:0] carry;

  assign carry[0] = ent;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    ls74161 #(
      .RST_Q (RST_VALUE[k*SLICE_W +: SLICE_W])
    ) u_slice (
      .clk    (clk),
      .clr_n  (rst_n),
      .load_n (load_n),
      .enp    (enp),
      .ent    (carry[k]),
      .d      (d[k*SLICE_W +: SLICE_W]),
      .q      (q[k*SLICE_W +: SLICE_W]),
      .rco    (carry[k+1])
    );
  end

  assign rco = carry[NSLICE];

endmodule
